pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_stage_skid.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Pipeline stage register with a valid/ready handshake and a two-entry skid
//   buffer (main register + skid register). Every output is a flop, so there
//   is no combinational path from m_ready_i to s_ready_o or from s_* to m_*.
//   A synchronous flush empties the stage. A saturating counter reports the
//   number of cycles the downstream side held off a valid beat.
//
// Ports
//   clk_i        in   1       clock, rising edge
//   rst_ni       in   1       asynchronous reset, active low
//   flush_i      in   1       discard held and incoming beats
//   clr_cnt_i    in   1       clear stall_cnt_o (wins over increment)
//   s_valid_i    in   1       upstream beat valid
//   s_ready_o    out  1       stage can accept a beat (registered)
//   s_data_i     in   DATA_W  upstream payload
//   m_valid_o    out  1       downstream beat valid (registered)
//   m_ready_i    in   1       downstream accepts a beat
//   m_data_o     out  DATA_W  downstream payload (registered)
//   stall_cnt_o  out  CNT_W   saturating count of m_valid_o & !m_ready_i
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                DATA_W  = 96,
    parameter logic [DATA_W-1:0] NOP_VAL = 'h13,
    parameter int                CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              clr_cnt_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   w_main_next;
    logic [DATA_W-1:0]   r_skid;
    logic [DATA_W-1:0]   w_skid_next;
    logic                r_m_valid;
    logic                r_s_ready;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_in;
    logic                w_out;
    logic                w_cnt_sat;

    assign w_in      = s_valid_i & r_s_ready;
    assign w_out     = r_m_valid & m_ready_i;
    assign w_cnt_sat = &r_cnt;

    // State register. The handshake flags are kept as their own flops, loaded
    // from the decoded next state, so both ports see a pure register output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_EMPTY;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_main    <= NOP_VAL;
            r_skid    <= NOP_VAL;
        end else begin
            r_state   <= w_state_next;
            r_m_valid <= (w_state_next != ST_EMPTY);
            r_s_ready <= (w_state_next != ST_FULL);
            r_main    <= w_main_next;
            r_skid    <= w_skid_next;
        end
    end

    // Next-state logic. Flush overrides every transition; a beat presented
    // in the same cycle is dropped even though it was handshaken upstream.
    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: if (w_in) w_state_next = ST_BUSY;
                ST_BUSY: begin
                    if (w_in && !w_out)      w_state_next = ST_FULL;
                    else if (!w_in && w_out) w_state_next = ST_EMPTY;
                end
                ST_FULL:  if (w_out) w_state_next = ST_BUSY;
                default:  w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Payload datapath. Empty slots are parked at NOP_VAL so downstream sees
    // a harmless instruction whenever m_valid_o is low.
    always_comb begin
        w_main_next = r_main;
        w_skid_next = r_skid;
        if (flush_i) begin
            w_main_next = NOP_VAL;
            w_skid_next = NOP_VAL;
        end else begin
            unique case (r_state)
                ST_EMPTY: if (w_in) w_main_next = s_data_i;
                ST_BUSY: begin
                    if (w_in && w_out)       w_main_next = s_data_i;
                    else if (w_in)           w_skid_next = s_data_i;
                    else if (w_out)          w_main_next = NOP_VAL;
                end
                ST_FULL: begin
                    // Skid holds the younger beat; promote it when the head leaves.
                    if (w_out) begin
                        w_main_next = r_skid;
                        w_skid_next = NOP_VAL;
                    end
                end
                default: begin
                    w_main_next = NOP_VAL;
                    w_skid_next = NOP_VAL;
                end
            endcase
        end
    end

    // Backpressure counter: independent of flush, clear beats increment,
    // holds at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_cnt <= '0;
        end else if (r_m_valid && !m_ready_i && !w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign s_ready_o   = r_s_ready;
    assign m_valid_o   = r_m_valid;
    assign m_data_o    = r_main;
    assign stall_cnt_o = r_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int          DATA_W  = 96;
    localparam int          CNT_W   = 4;
    localparam logic [95:0] NOP     = 96'h13;
    localparam int          CNT_MAX = 15;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              clr_cnt;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .DATA_W  (DATA_W),
        .NOP_VAL (NOP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .clr_cnt_i   (clr_cnt),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .stall_cnt_o (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity two. The head is what
    // downstream sees; an empty FIFO shows NOP.
    logic [95:0] mq[$];
    int          mcnt = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mcnt = 0;
            end else begin
                automatic bit acc = s_valid && (mq.size() < 2);
                automatic bit dlv = (mq.size() > 0) && m_ready;
                if (clr_cnt)
                    mcnt = 0;
                else if ((mq.size() > 0) && !m_ready && mcnt < CNT_MAX)
                    mcnt = mcnt + 1;
                if (flush) begin
                    mq.delete();
                end else begin
                    if (dlv) void'(mq.pop_front());
                    if (acc) mq.push_back(s_data);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("model_m_valid", {95'd0, m_valid}, {95'd0, mq.size() > 0});
                chk("model_s_ready", {95'd0, s_ready}, {95'd0, mq.size() < 2});
                chk("model_m_data", m_data, (mq.size() > 0) ? mq[0] : NOP);
                chk("model_stall_cnt", {92'd0, stall_cnt}, 96'(mcnt));
            end
        end
    end

    // One cycle: apply inputs, let one rising edge pass, return just after it.
    task automatic drive(input logic v, input logic [95:0] d, input logic r,
                         input logic f, input logic c);
        s_valid = v;
        s_data  = d;
        m_ready = r;
        flush   = f;
        clr_cnt = c;
        @(posedge clk);
        #1;
        $display("cyc v=%0b d=%0h r=%0b f=%0b c=%0b -> mv=%0b md=%0h sr=%0b cnt=%0d",
                 v, d, r, f, c, m_valid, m_data, s_ready, stall_cnt);
    endtask

    task automatic lit(input string tag, input logic mv, input logic [95:0] md,
                       input logic sr, input int cnt);
        chk({tag, "_m_valid"}, {95'd0, m_valid}, {95'd0, mv});
        chk({tag, "_m_data"}, m_data, md);
        chk({tag, "_s_ready"}, {95'd0, s_ready}, {95'd0, sr});
        chk({tag, "_cnt"}, {92'd0, stall_cnt}, 96'(cnt));
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        clr_cnt = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 1'b0, NOP, 1'b1, 0);
        rst_n = 1'b1;

        // Streaming at full throughput.
        drive(1'b1, 96'hA, 1'b1, 1'b0, 1'b0); lit("t1_a", 1'b1, 96'hA, 1'b1, 0);
        drive(1'b1, 96'hB, 1'b1, 1'b0, 1'b0); lit("t1_b", 1'b1, 96'hB, 1'b1, 0);
        drive(1'b1, 96'hC, 1'b1, 1'b0, 1'b0); lit("t1_c", 1'b1, 96'hC, 1'b1, 0);
        drive(1'b0, 96'h0, 1'b1, 1'b0, 1'b0); lit("t1_drain", 1'b0, NOP, 1'b1, 0);

        // Backpressure fills the skid, then drains in order.
        drive(1'b1, 96'h1, 1'b0, 1'b0, 1'b0); lit("t2_busy", 1'b1, 96'h1, 1'b1, 0);
        drive(1'b1, 96'h2, 1'b0, 1'b0, 1'b0); lit("t2_full", 1'b1, 96'h1, 1'b0, 1);
        drive(1'b0, 96'h0, 1'b1, 1'b0, 1'b0); lit("t2_out1", 1'b1, 96'h2, 1'b1, 1);
        drive(1'b0, 96'h0, 1'b1, 1'b0, 1'b0); lit("t2_out2", 1'b0, NOP, 1'b1, 1);

        // Flush while full, with a concurrent upstream beat that must vanish.
        drive(1'b1, 96'h4, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 96'h5, 1'b0, 1'b0, 1'b0); lit("t3_full", 1'b1, 96'h4, 1'b0, 2);
        drive(1'b1, 96'h3, 1'b0, 1'b1, 1'b0); lit("t3_flush", 1'b0, NOP, 1'b1, 3);
        drive(1'b0, 96'h0, 1'b1, 1'b0, 1'b0); lit("t3_after", 1'b0, NOP, 1'b1, 3);

        // Counter clear, saturation, and independence from flush.
        drive(1'b0, 96'h0, 1'b1, 1'b0, 1'b1); lit("t4_clr", 1'b0, NOP, 1'b1, 0);
        drive(1'b1, 96'h7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 96'h0, 1'b0, 1'b0, 1'b0);
        lit("t4_sat", 1'b1, 96'h7, 1'b1, 15);
        drive(1'b0, 96'h0, 1'b0, 1'b0, 1'b1); lit("t4_clr2", 1'b1, 96'h7, 1'b1, 0);
        drive(1'b0, 96'h0, 1'b0, 1'b0, 1'b0); lit("t4_inc", 1'b1, 96'h7, 1'b1, 1);
        drive(1'b0, 96'h0, 1'b0, 1'b1, 1'b0); lit("t4_flush", 1'b0, NOP, 1'b1, 2);
        drive(1'b0, 96'h0, 1'b0, 1'b0, 1'b0); lit("t4_hold", 1'b0, NOP, 1'b1, 2);

        // Asynchronous reset mid-cycle while busy.
        drive(1'b1, 96'h9, 1'b1, 1'b0, 1'b0); lit("t5_busy", 1'b1, 96'h9, 1'b1, 2);
        #3 rst_n = 1'b0;
        #1 lit("t5_async", 1'b0, NOP, 1'b1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic, checked every cycle by the model compare process.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 127) == 0));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
